// File: rtl/seq_pat_tx_if.sv
// ----------------------------------------------------------------------------
// seq_pat_tx_if
//
// Purpose:
//    Bundles the control inputs and serial outputs of the serial pattern
//    transmitter so the transmitter and whatever drives it (a controller or a
//    bench) can be wired with a single connection.
//
// Signals:
//    start        request to begin a burst (only honoured while idle)
//    stop         request to end a burst after the current frame
//    pat_sel      0 = built-in pattern, 1 = pat_in
//    pat_in       programmable pattern, PAT_W bits
//    reps         frames per burst, 0 = run until stop
//    gap          idle cycles between frames, 0 = back-to-back
//    seq          serial data bit
//    seq_vld      seq carries a pattern bit
//    frame_start  pulse on the first (MSB) bit of each frame
//    busy         transmitter is not idle
//    done         pulse marking the end of a burst
//
// Modports:
//    master  drives the controls, observes the serial outputs
//    slave   the transmitter itself
// ----------------------------------------------------------------------------
interface seq_pat_tx_if #(
   parameter int PAT_W = 7,
   parameter int CNT_W = 4,
   parameter int GAP_W = 4
);

   logic             start;
   logic             stop;
   logic             pat_sel;
   logic [PAT_W-1:0] pat_in;
   logic [CNT_W-1:0] reps;
   logic [GAP_W-1:0] gap;

   logic             seq;
   logic             seq_vld;
   logic             frame_start;
   logic             busy;
   logic             done;

   modport master (
      output start, stop, pat_sel, pat_in, reps, gap,
      input  seq, seq_vld, frame_start, busy, done
   );

   modport slave (
      input  start, stop, pat_sel, pat_in, reps, gap,
      output seq, seq_vld, frame_start, busy, done
   );

endinterface

// File: rtl/seq_pat_tx.sv
// ----------------------------------------------------------------------------
// seq_pat_tx
//
// Purpose:
//    Serial pattern transmitter. Sends a PAT_W-bit pattern MSB first, one bit
//    per clock, for a programmable number of frames separated by a
//    programmable number of idle cycles. Used to feed the serial sequence
//    detectors, both for stimulus and for on-chip loopback self-test.
//
// Parameters:
//    PAT_W    pattern length in bits (2..16)
//    PATTERN  built-in pattern, sent MSB first
//    CNT_W    width of the frame-repeat count
//    GAP_W    width of the inter-frame gap count
//
// Ports:
//    clk   system clock, rising edge
//    rst   asynchronous active-low reset, released synchronously to clk
//    bus   seq_pat_tx_if slave modport (controls in, serial outputs out)
//
// Timing:
//    start sampled at edge N puts the MSB on seq (with seq_vld and
//    frame_start) from edge N+1; the frame occupies edges N+1 .. N+PAT_W.
//    Every output is a register reflecting the state during the cycle
//    before the edge, so busy rises together with the first bit and the
//    done pulse appears one edge after the last bit.
// ----------------------------------------------------------------------------
module seq_pat_tx #(
   parameter int               PAT_W   = 7,
   parameter logic [PAT_W-1:0] PATTERN = 7'b1101100,
   parameter int               CNT_W   = 4,
   parameter int               GAP_W   = 4
) (
   input  logic          clk,
   input  logic          rst,
   seq_pat_tx_if.slave   bus
);

   localparam int               IDX_W    = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP,
      ST_DONE
   } state_t;

   state_t           state;

   // Burst parameters latched at start so the inputs may change freely
   // while a burst is in progress.
   logic [PAT_W-1:0] shadow_pat;
   logic [CNT_W-1:0] shadow_reps;
   logic [GAP_W-1:0] shadow_gap;

   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] frame_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             stop_pend;

   logic [CNT_W-1:0] frame_next;
   logic [GAP_W-1:0] gap_last;
   logic             reps_reached;
   logic             end_burst;

   // Frame count including the frame that is finishing this cycle; with
   // reps = 0 the counter simply wraps and never ends the burst.
   assign frame_next   = frame_cnt + CNT_W'(1);
   assign reps_reached = (shadow_reps != '0) && (frame_next == shadow_reps);

   // A stop arriving on the very last bit still counts: the frame is
   // complete at that point, so there is nothing left to protect.
   assign end_burst    = stop_pend || bus.stop || reps_reached;

   // Last gap count value; only meaningful when the shadow gap is non-zero.
   assign gap_last     = shadow_gap - GAP_W'(1);

   // Single FSM block. Each branch registers the outputs that belong to the
   // current state and chooses the next state. frame_start and done are
   // pulses, so they default low and are raised only where needed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= ST_IDLE;
         shadow_pat      <= '0;
         shadow_reps     <= '0;
         shadow_gap      <= '0;
         idx             <= '0;
         frame_cnt       <= '0;
         gap_cnt         <= '0;
         stop_pend       <= 1'b0;
         bus.seq         <= 1'b0;
         bus.seq_vld     <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
      end else begin
         bus.frame_start <= 1'b0;
         bus.done        <= 1'b0;

         case (state)
            ST_IDLE: begin
               bus.seq     <= 1'b0;
               bus.seq_vld <= 1'b0;
               bus.busy    <= 1'b0;
               // stop is meaningless here; a simultaneous start wins.
               if (bus.start) begin
                  shadow_pat  <= bus.pat_sel ? bus.pat_in : PATTERN;
                  shadow_reps <= bus.reps;
                  shadow_gap  <= bus.gap;
                  idx         <= '0;
                  frame_cnt   <= '0;
                  gap_cnt     <= '0;
                  stop_pend   <= 1'b0;
                  state       <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               bus.seq         <= shadow_pat[LAST_IDX - idx];
               bus.seq_vld     <= 1'b1;
               bus.busy        <= 1'b1;
               bus.frame_start <= (idx == '0);
               // A stop is remembered so the frame is never truncated.
               if (bus.stop) begin
                  stop_pend <= 1'b1;
               end
               if (idx == LAST_IDX) begin
                  idx       <= '0;
                  frame_cnt <= frame_next;
                  if (end_burst) begin
                     state <= ST_DONE;
                  end else if (shadow_gap != '0) begin
                     gap_cnt <= '0;
                     state   <= ST_GAP;
                  end
                  // Otherwise stay in SHIFT: the next frame follows
                  // immediately with idx back at 0.
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end

            ST_GAP: begin
               bus.seq     <= 1'b0;
               bus.seq_vld <= 1'b0;
               bus.busy    <= 1'b1;
               // No frame is in flight during the gap, so stop acts at once.
               if (bus.stop) begin
                  state <= ST_DONE;
               end else if (gap_cnt == gap_last) begin
                  gap_cnt <= '0;
                  state   <= ST_SHIFT;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end

            ST_DONE: begin
               // start is deliberately not looked at here.
               bus.seq     <= 1'b0;
               bus.seq_vld <= 1'b0;
               bus.busy    <= 1'b1;
               bus.done    <= 1'b1;
               stop_pend   <= 1'b0;
               state       <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
